// File: rtl/tensor_unflatten_streamer.sv
// rtl/tensor_unflatten_streamer.sv - captures a flattened tensor and streams its elements in k/j/i order with coordinates
module tensor_unflatten_streamer #(
  parameter int WIDTH     = 4,
  parameter int HEIGHT    = 8,
  parameter int DEPTH     = 4,
  parameter int DATA_SIZE = 16,
  localparam int N  = WIDTH * HEIGHT * DEPTH,
  localparam int IW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int JW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int KW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_SIZE-1:0] in_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic [IW-1:0]          out_i,
  output logic [JW-1:0]          out_j,
  output logic [KW-1:0]          out_k,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);
  localparam logic [JW-1:0] J_LAST = JW'(HEIGHT - 1);
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [JW-1:0]          j_q, j_d;
  logic [KW-1:0]          k_q, k_d;
  logic [N*DATA_SIZE-1:0] buf_q, buf_d;

  logic fire;
  logic capture;
  int   elem_idx;

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) && (i_q == I_LAST) && (j_q == J_LAST) && (k_q == K_LAST);
  assign fire      = out_valid && out_ready;
  assign in_ready  = ((state_q == IDLE) && !flush) || (fire && out_last && !flush);
  assign capture   = in_valid && in_ready;

  assign out_i = i_q;
  assign out_j = j_q;
  assign out_k = k_q;

  // Constant part-selects keep the element mux free of wide variable indices.
  assign elem_idx = (int'(i_q) * HEIGHT + int'(j_q)) * DEPTH + int'(k_q);

  always_comb begin
    out_data = '0;
    for (int n = 0; n < N; n++) begin
      if (elem_idx == n) out_data = buf_q[n*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    buf_d   = buf_q;
    if (flush) begin
      state_d = IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end else if (capture) begin
      state_d = STREAM;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      buf_d   = in_flat;
    end else if (fire) begin
      if (out_last) begin
        state_d = IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end else if (k_q == K_LAST) begin
        k_d = '0;
        if (j_q == J_LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_tensor_unflatten_streamer.sv
// tb/tb_tensor_unflatten_streamer.sv - vector-table bench for tensor_unflatten_streamer (2x2x2 and 1x1x1)
module tb_tensor_unflatten_streamer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        fl, iv, ordy, ov, irdy, last, busy;
  logic [63:0] flat;
  logic [7:0]  od;
  logic        oi, oj, ok;

  logic        fl1, iv1, ordy1, ov1, irdy1, last1, busy1;
  logic [7:0]  flat1, od1;
  logic        oi1, oj1, ok1;

  tensor_unflatten_streamer #(.WIDTH(2), .HEIGHT(2), .DEPTH(2), .DATA_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_ready(irdy), .in_flat(flat),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_i(oi), .out_j(oj), .out_k(ok),
    .out_last(last), .busy(busy)
  );

  tensor_unflatten_streamer #(.WIDTH(1), .HEIGHT(1), .DEPTH(1), .DATA_SIZE(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .in_valid(iv1), .in_ready(irdy1), .in_flat(flat1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_i(oi1), .out_j(oj1), .out_k(ok1),
    .out_last(last1), .busy(busy1)
  );

  typedef struct {
    logic       iv, ordy, fl, sel;
    logic       ov;
    logic [7:0] data;
    logic [2:0] ijk;
    logic       last, irdy;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] flat_a, flat_b;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic a_iv, a_ordy, a_fl, a_sel, a_ov,
                              input logic [7:0] a_data, input logic [2:0] a_ijk,
                              input logic a_last, a_irdy);
    vec_t v;
    v.iv = a_iv; v.ordy = a_ordy; v.fl = a_fl; v.sel = a_sel; v.ov = a_ov;
    v.data = a_data; v.ijk = a_ijk; v.last = a_last; v.irdy = a_irdy;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int n = 0; n < 8; n++) begin
      flat_a[n*8 +: 8] = 8'(8'h10 + n);
      flat_b[n*8 +: 8] = 8'(8'h20 + n);
    end

    // Post-reset idle, then a single tensor with out_ready held high
    add(0,1,0,0, 0,8'h10 & 8'h00,3'd0,0,1);
    add(1,1,0,0, 0,8'h00,3'd0,0,1);
    for (int n = 0; n < 8; n++) add(0,1,0,0, 1,8'(8'h10+n),3'(n),n==7,n==7);
    add(0,1,0,0, 0,8'h10,3'd0,0,1);
    // out_ready toggling, in_flat switched to B while streaming must not leak in
    add(1,0,0,0, 0,8'h10,3'd0,0,1);
    for (int n = 0; n < 8; n++) begin
      add(0,0,0,1, 1,8'(8'h10+n),3'(n),n==7,0);
      add(0,1,0,1, 1,8'(8'h10+n),3'(n),n==7,n==7);
    end
    add(0,1,0,0, 0,8'h10,3'd0,0,1);
    // Back-to-back: B captured on the cycle A's last element is accepted
    add(1,1,0,0, 0,8'h10,3'd0,0,1);
    for (int n = 0; n < 8; n++) add(1,1,0,1, 1,8'(8'h10+n),3'(n),n==7,n==7);
    for (int n = 0; n < 8; n++) add(0,1,0,1, 1,8'(8'h20+n),3'(n),n==7,n==7);
    add(0,1,0,1, 0,8'h20,3'd0,0,1);
    // Flush after element 13, with in_valid raised to prove nothing is captured
    add(1,1,0,0, 0,8'h20,3'd0,0,1);
    for (int n = 0; n < 4; n++) add(0,1,0,0, 1,8'(8'h10+n),3'(n),0,0);
    add(1,0,1,1, 1,8'h14,3'd4,0,0);
    add(0,1,0,0, 0,8'h10,3'd0,0,1);
    add(1,1,1,1, 0,8'h10,3'd0,0,0);
    add(0,1,0,0, 0,8'h10,3'd0,0,1);
    add(1,1,0,0, 0,8'h10,3'd0,0,1);
    for (int n = 0; n < 8; n++) add(0,1,0,0, 1,8'(8'h10+n),3'(n),n==7,n==7);
    add(0,1,0,0, 0,8'h10,3'd0,0,1);

    rst_n = 1'b0;
    fl = 0; iv = 0; ordy = 0; flat = '0;
    fl1 = 0; iv1 = 0; ordy1 = 0; flat1 = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(ov), 32'd0);
    check("reset_out_data", 32'(od), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_last", 32'(last), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      iv = vecs[r].iv; ordy = vecs[r].ordy; fl = vecs[r].fl;
      flat = vecs[r].sel ? flat_b : flat_a;
      #1;
      check($sformatf("row%0d_out_valid", r), 32'(ov), 32'(vecs[r].ov));
      check($sformatf("row%0d_out_data", r), 32'(od), 32'(vecs[r].data));
      check($sformatf("row%0d_coord", r), 32'({oi, oj, ok}), 32'(vecs[r].ijk));
      check($sformatf("row%0d_out_last", r), 32'(last), 32'(vecs[r].last));
      check($sformatf("row%0d_in_ready", r), 32'(irdy), 32'(vecs[r].irdy));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].ov));
    end

    // Asynchronous reset while element 13 is on the output
    @(negedge clk); iv = 1; ordy = 1; flat = flat_a; fl = 0;
    @(negedge clk); iv = 0;
    for (int n = 0; n < 3; n++) begin
      #1 check($sformatf("pre_rst_data%0d", n), 32'(od), 32'(8'h10 + n));
      @(negedge clk);
    end
    ordy = 0;
    #1 check("pre_rst_data3", 32'(od), 32'h13);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(ov), 32'd0);
    check("async_rst_out_data", 32'(od), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_out_last", 32'(last), 32'd0);
    @(negedge clk); rst_n = 1'b1; ordy = 1;
    #1;
    check("rst_release_in_ready", 32'(irdy), 32'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      check($sformatf("post_rst_out_valid%0d", n), 32'(ov), 32'd0);
      check($sformatf("post_rst_out_data%0d", n), 32'(od), 32'd0);
    end

    // Degenerate 1x1x1 tensor
    @(negedge clk);
    check("n1_idle_out_valid", 32'(ov1), 32'd0);
    iv1 = 1; ordy1 = 0; flat1 = 8'h5A;
    #1 check("n1_in_ready_idle", 32'(irdy1), 32'd1);
    @(negedge clk); iv1 = 0; flat1 = 8'hA5;
    #1;
    check("n1_stall_out_valid", 32'(ov1), 32'd1);
    check("n1_stall_out_last", 32'(last1), 32'd1);
    check("n1_stall_in_ready", 32'(irdy1), 32'd0);
    @(negedge clk); ordy1 = 1;
    #1;
    check("n1_out_data", 32'(od1), 32'h5A);
    check("n1_coord", 32'({oi1, oj1, ok1}), 32'd0);
    check("n1_out_last", 32'(last1), 32'd1);
    check("n1_in_ready_last", 32'(irdy1), 32'd1);
    @(negedge clk); #1;
    check("n1_done_out_valid", 32'(ov1), 32'd0);
    check("n1_done_busy", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tensor_unflatten_streamer.md
TENSOR_UNFLATTEN_STREAMER -- requirements
Module: tensor_unflatten_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning tensor dimension i extent.
REQ-002 SHALL have parameter HEIGHT, default 8, meaning tensor dimension j extent.
REQ-003 SHALL have parameter DEPTH, default 4, meaning tensor dimension k extent.
REQ-004 SHALL have parameter DATA_SIZE, default 16, meaning element width in bits; N = WIDTH*HEIGHT*DEPTH elements per tensor.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-006 flush  input  1  synchronous abort of the tensor in progress.
REQ-007 in_valid  input  1  in_flat holds a valid flattened tensor.
REQ-008 in_ready  output  1  block accepts in_flat this cycle.
REQ-009 in_flat  input  N*DATA_SIZE  flattened tensor; element [i][j][k] at bit offset ((i*HEIGHT+j)*DEPTH+k)*DATA_SIZE, LSB first.
REQ-010 out_valid  output  1  out_data/coordinates valid.
REQ-011 out_ready  input  1  downstream accepts element.
REQ-012 out_data  output  DATA_SIZE  current element.
REQ-013 out_i, out_j, out_k  output  max(1,clog2(WIDTH/HEIGHT/DEPTH)) each  coordinates of out_data.
REQ-014 out_last  output  1  current element is index N-1.
REQ-015 busy  output  1  a tensor is held (state STREAM).

Function
REQ-016 SHALL implement states IDLE and STREAM.
REQ-017 in_ready SHALL equal (state==IDLE && !flush) || (out_valid && out_ready && out_last && !flush).
REQ-018 On in_valid && in_ready, SHALL register in_flat into an internal buffer, clear counters to (0,0,0), enter STREAM.
REQ-019 out_valid SHALL be 1 exactly when state==STREAM; first element visible the cycle after capture (latency 1).
REQ-020 out_data SHALL be the buffer slice selected by registered counters (i,j,k); out_i/out_j/out_k SHALL equal those counters.
REQ-021 Emission order SHALL be k fastest, then j, then i: linear index 0..N-1.
REQ-022 On out_valid && out_ready and not last: k increments; k wraps DEPTH-1->0 carrying into j; j wraps HEIGHT-1->0 carrying into i.
REQ-023 out_last SHALL be 1 when i==WIDTH-1, j==HEIGHT-1, k==DEPTH-1 and state==STREAM.
REQ-024 On last element accepted with no new capture, SHALL return to IDLE.
REQ-025 On last element accepted with simultaneous in_valid (in_ready=1), SHALL capture the new tensor and remain in STREAM with counters (0,0,0): zero-bubble back-to-back.
REQ-026 While out_valid && !out_ready, out_data, coordinates and out_last SHALL hold stable.
REQ-027 in_flat changes while in STREAM SHALL NOT affect out_data (buffer is only written on capture).
REQ-028 flush SHALL force IDLE and zero counters next cycle from any state; flush with in_valid in IDLE SHALL capture nothing.
REQ-029 Dimensions of extent 1 SHALL work (counter stays 0, carry immediate); N=1 SHALL give out_last on first element.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, counters 0, buffer 0, out_valid 0, out_last 0, busy 0, out_data 0.
REQ-031 After rst_n deasserts, in_ready SHALL be 1 in the first cycle (flush low); reset mid-stream SHALL discard the held tensor.

Verification (WIDTH=2, HEIGHT=2, DEPTH=2, DATA_SIZE=8, in_flat element n = 8'h10+n)
REQ-032 Single tensor, out_ready=1 -> 8 consecutive outputs 10..17, coordinates (0,0,0)..(1,1,1), out_last only on 17, then IDLE, busy 0.
REQ-033 out_ready toggled 1/0 each cycle -> same 10..17 sequence, outputs stable during stalls, 16 cycles total streaming.
REQ-034 Two tensors back-to-back (second value 8'h20+n, in_valid held) -> 10..17 then 20..27 with no idle cycle between 17 and 20.
REQ-035 flush asserted after element 13 accepted -> next cycle out_valid 0, in_ready 1; new tensor starts at 10 with (0,0,0).
REQ-036 rst_n pulsed low mid-stream (after 12) -> out_valid 0 immediately (async), in_ready 1 after release, no residual output.
REQ-037 Config WIDTH=HEIGHT=DEPTH=1 -> single output with out_last=1 and coordinates 0, then IDLE.
